// File: rtl/mul_buffer_pkg.sv
// Shared constants and types for the multiplier operand buffer.
// The package defaults match the Euler datapath's native operand width.
package mul_buffer_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/mul_operand_ram.sv
// Operand-pair register file: one synchronous write port and one asynchronous read port.
// The storage has no reset, so a flush only needs to rewind the pointers.
module mul_operand_ram
    import mul_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [2*WIDTH-1:0]   wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [2*WIDTH-1:0]   rd_data
);

    logic [2*WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // The read is combinational so the head pair falls through without an extra cycle.
    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/mul_operand_fifo.sv
// First-word-fall-through buffer of (a, b) operand pairs that feeds the multiplier.
// Provides valid/ready handshakes, flush, occupancy status and zeroed outputs while empty.
module mul_operand_fifo
    import mul_buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_sync,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_wr_en;
    logic [2*WIDTH-1:0] w_rd_data;

    // Full and empty come from the count so a wrapped pointer pair is never ambiguous.
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    assign in_ready  = !w_full && !flush;
    assign out_valid = !w_empty;

    assign w_push  = in_valid && in_ready;
    assign w_pop   = out_valid && out_ready;
    assign w_wr_en = w_push && !rst_sync;

    always_ff @(posedge clk) begin
        if (rst_sync || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    mul_operand_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr),
        .wr_data ({in_a, in_b}),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // Stale storage must never leak to the multiplier, so the head is masked while empty.
    assign out_a = w_empty ? '0 : w_rd_data[2*WIDTH-1:WIDTH];
    assign out_b = w_empty ? '0 : w_rd_data[WIDTH-1:0];

    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: tb/tb_mul_operand_fifo.sv
// Scoreboard bench for mul_operand_fifo: directed scenarios followed by randomized traffic,
// checked every cycle against a queue-based model of the buffer contents.
module tb_mul_operand_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst_sync;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [AW:0]      count;
    logic             full;
    logic             empty;

    always #5 clk = ~clk;

    mul_operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_sync  (rst_sync),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t sb_q[$];
    int    n_checks   = 0;
    int    n_pass     = 0;
    bit    model_live = 1'b0;
    bit    verbose    = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs that the next rising edge samples.
    always @(negedge clk) begin
        int    n;
        bit    do_pop;
        bit    do_push;
        pair_t p;
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;

        n = sb_q.size();
        if (model_live) begin
            exp_a = '0;
            exp_b = '0;
            if (n > 0) begin
                exp_a = sb_q[0].a;
                exp_b = sb_q[0].b;
            end
            check("count",     32'(count),     32'(n));
            check("empty",     32'(empty),     32'(n == 0));
            check("full",      32'(full),      32'(n == DEPTH));
            check("out_valid", 32'(out_valid), 32'(n > 0));
            check("in_ready",  32'(in_ready),  32'((n < DEPTH) && !flush));
            check("out_a",     32'(out_a),     32'(exp_a));
            check("out_b",     32'(out_b),     32'(exp_b));
            if (verbose && n > 0 && out_ready && !rst_sync && !flush) begin
                $display("pop  a=0x%02h b=0x%02h (expected a=0x%02h b=0x%02h)", out_a, out_b, exp_a, exp_b);
            end
        end

        if (rst_sync) begin
            sb_q.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            if (flush) begin
                sb_q.delete();
            end else begin
                do_pop  = out_ready && (n > 0);
                do_push = in_valid && (n < DEPTH);
                if (do_pop) begin
                    void'(sb_q.pop_front());
                end
                if (do_push) begin
                    p.a = in_a;
                    p.b = in_b;
                    sb_q.push_back(p);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst_sync  = 1'b0;
    endtask

    task automatic push_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic rdy);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_sync  = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        repeat (3) step();

        // Reset then idle
        idle();
        repeat (10) step();

        // Single pair, then consume it
        push_one(8'h12, 8'h34, 1'b0);
        step();
        out_ready = 1'b1;
        step();
        idle();
        repeat (2) step();

        // Fill, offer a fifth pair while full, then drain
        for (int i = 1; i <= 4; i++) begin
            push_one(8'(i), 8'(8'hF0 + i), 1'b0);
        end
        in_valid = 1'b1;
        in_a     = 8'h05;
        in_b     = 8'hF5;
        repeat (3) step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        idle();
        step();

        // Streaming with a preload of two: the pointers wrap repeatedly at constant occupancy
        push_one(8'h20, 8'h40, 1'b0);
        push_one(8'h21, 8'h41, 1'b0);
        for (int i = 0; i < 12; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_a      = 8'(8'h30 + i);
            in_b      = 8'(8'h60 + i);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        idle();
        step();

        // Flush with a simultaneous pop, then a fresh pair
        for (int i = 0; i < 3; i++) begin
            push_one(8'(8'h70 + i), 8'(8'h80 + i), 1'b0);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        idle();
        step();
        push_one(8'hAA, 8'h55, 1'b0);
        step();
        out_ready = 1'b1;
        step();
        idle();
        step();

        // Reset mid-operation with a push and a pop offered
        push_one(8'h91, 8'h92, 1'b0);
        push_one(8'h93, 8'h94, 1'b0);
        rst_sync  = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'hEE;
        in_b      = 8'hDD;
        out_ready = 1'b1;
        step();
        idle();
        repeat (3) step();
        push_one(8'hC1, 8'hC2, 1'b0);
        out_ready = 1'b1;
        repeat (2) step();
        idle();
        step();

        // Randomized traffic with varying pressure, occasional flush and reset
        verbose = 1'b0;
        for (int seg = 0; seg < 12; seg++) begin
            int pv;
            int pr;
            pv = 20 + 15 * (seg % 5);
            pr = 90 - 15 * ((seg * 3) % 5);
            for (int c = 0; c < 200; c++) begin
                in_valid  = ($urandom_range(0, 99) < pv);
                out_ready = ($urandom_range(0, 99) < pr);
                in_a      = 8'($urandom);
                in_b      = 8'($urandom);
                flush     = ($urandom_range(0, 63) == 0);
                rst_sync  = ($urandom_range(0, 255) == 0);
                step();
            end
        end
        idle();
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
